// File: rtl/deser7_sync_pkg.sv
// Shared receive-side framing constants.
// State encodings and the sync pattern, also used by the framer.
package deser7_sync_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    DATA     = 2'd1,
    SYNC_CHK = 2'd2
  } state_e;

  localparam logic [6:0] SYNC_DEFAULT = 7'b1110101;

endpackage

// File: rtl/deser7_sync_sipo.sv
// Serial-in shift history with enable and sync reset.
// word presents the full WIDTH-bit window including the incoming bit.
module deser7_sync_sipo #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-2:0] q_q;
  logic [WIDTH-2:0] q_d;

  assign word = {q_q, din};

  // shift one bit in on each enabled cycle
  always_comb begin
    q_d = q_q;
    if (en) q_d = word[WIDTH-2:0];
  end

  // history register
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/deser7_sync.sv
// Serial receive deframer: sync hunt, word assembly, flywheel.
// Lock is dropped after MISS_MAX consecutive bad syncs.
module deser7_sync
  import deser7_sync_pkg::*;
#(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SYNC_DEFAULT),
  parameter int               FRAME_WORDS = 4,
  parameter int               MISS_MAX    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             locked,
  output logic [7:0]       sync_err_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FILL_MAX  = CW'(WIDTH);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WW-1:0]    word_q, word_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             fs_q, fs_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] nxt;

  deser7_sync_sipo #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk  (clk),
    .rst  (rst),
    .en   (din_valid),
    .din  (din),
    .word (nxt)
  );

  // next-state, counters and registered strobes
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    word_d  = word_q;
    miss_d  = miss_q;
    err_d   = err_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    fs_d    = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (fill_q >= BIT_LAST && nxt == SYNC_WORD) begin
            state_d = DATA;
            bit_d   = '0;
            word_d  = '0;
            miss_d  = '0;
            fs_d    = 1'b1;
          end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_q == BIT_LAST) begin
            bit_d  = '0;
            dout_d = nxt;
            dv_d   = 1'b1;
            if (word_q == WORD_LAST) begin
              word_d  = '0;
              state_d = SYNC_CHK;
            end else begin
              word_d = word_q + WW'(1);
            end
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
        SYNC_CHK: begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (nxt == SYNC_WORD) begin
              miss_d  = '0;
              fs_d    = 1'b1;
              state_d = DATA;
            end else begin
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
              if (miss_q == MISS_LAST) begin
                miss_d  = '0;
                fill_d  = '0;
                state_d = HUNT;
              end else begin
                miss_d  = miss_q + MW'(1);
                fs_d    = 1'b1;
                state_d = DATA;
              end
            end
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    lock_d = (state_d == DATA) || (state_d == SYNC_CHK);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      fill_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
      lock_q  <= lock_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dv_q;
  assign frame_start  = fs_q;
  assign locked       = lock_q;
  assign sync_err_cnt = err_q;

endmodule
